// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: single-port data RAM with byte-lane strobes, valid/ready handshake
// and WAIT_CYC wait states per access. Define DMEM_RANGE_CHK_EN for range/alignment errors.
`timescale 1ns/1ps
module dmem_wait_ctrl #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       WAIT_CYC  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned BYTE_SH = $clog2(STRB_W);
  localparam int unsigned IDX_W   = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                do_access;
  logic                accept;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_strb;
  logic [ADDR_W-1:0]   offset;
  logic [IDX_W-1:0]    idx;
  logic                acc_err;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign accept = req_valid_i && (state == IDLE);
  assign offset = lat_addr - BASE_ADDR;
  // Truncation to IDX_W bits gives the modulo-DEPTH wrap when checking is off.
  assign idx    = IDX_W'(offset >> BYTE_SH);

`ifdef DMEM_RANGE_CHK_EN
  assign acc_err = (lat_addr < BASE_ADDR)
                || ((offset >> BYTE_SH) >= ADDR_W'(DEPTH))
                || ((lat_addr & ADDR_W'(STRB_W - 1)) != '0);
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(WAIT_CYC);
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we_i;
        lat_addr  <= req_addr_i;
        lat_wdata <= req_wdata_i;
        lat_strb  <= req_strb_i;
      end
      if (do_access) begin
        rdata_q <= (lat_we || acc_err) ? '0 : mem[idx];
        err_q   <= acc_err;
      end
    end
  end

  // Array is not reset; a reset in BUSY leaves state IDLE so do_access never fires.
  always_ff @(posedge clk) begin
    if (do_access && lat_we && !acc_err) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (lat_strb[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Self-checking bench for dmem_wait_ctrl: two instances (WAIT_CYC 0 and 3) driven with
// directed and random transactions against a word/byte-level reference memory.
`timescale 1ns/1ps
module tb_dmem_wait_ctrl;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef DMEM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_strb  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mdl   [2][DEPTH];
  bit   [3:0]  known [2][DEPTH];

  always #5 clk = ~clk;

  dmem_wait_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_strb_i(req_strb[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  dmem_wait_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .WAIT_CYC(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_strb_i(req_strb[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  function automatic int unsigned wc(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit mdl_err(input logic [31:0] a);
    if (!CHK) return 1'b0;
    return (a < BASE) || (((a - BASE) / 4) >= DEPTH) || ((a % 4) != 0);
  endfunction

  function automatic int unsigned mdl_idx(input logic [31:0] a);
    return ((a - BASE) / 4) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Starts and ends #1 after a rising edge.
  task automatic txn(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int hold,
                     output logic [31:0] rd, output logic err);
    int unsigned n;
    int unsigned idx;
    bit          e;
    bit          rd_known;
    logic [31:0] exp_rd;
    e        = mdl_err(addr);
    idx      = mdl_idx(addr);
    exp_rd   = '0;
    rd_known = 1'b1;
    if (!we && !e) begin
      exp_rd   = mdl[k][idx];
      rd_known = (known[k][idx] == 4'hF);
    end
    chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_strb[k]  = strb;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_strb[k]  = 4'($urandom);
    if (we && !e) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) begin
          mdl[k][idx][8*i +: 8] = wdata[8*i +: 8];
          known[k][idx][i]      = 1'b1;
        end
      end
    end
    chk("req_ready_busy", 32'(req_ready[k]), 32'd0);
    n = 0;
    while (!rsp_valid[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, wc(k) + 1);
    rd  = rsp_rdata[k];
    err = rsp_err[k];
    if (rd_known) chk("rdata", rd, exp_rd);
    chk("err", 32'(err), 32'(e));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("valid_hold", 32'(rsp_valid[k]), 32'd1);
      chk("rdata_hold", rsp_rdata[k], rd);
      chk("ready_hold", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    chk("valid_drop", 32'(rsp_valid[k]), 32'd0);
    chk("ready_back", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    bit          seen;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0;   req_strb[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_rdata", rsp_rdata[1], 32'd0);
    chk("rst_err", 32'(rsp_err[1]), 32'd0);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk("idle_ready", 32'(req_ready[k]), 32'd1);
        chk("idle_valid", 32'(rsp_valid[k]), 32'd0);
        chk("idle_rdata", rsp_rdata[k], 32'd0);
      end
    end

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 8; w++)
        txn(k, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd, err);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, err);
    chk("wr_rdata_zero", rd, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd, err);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err);
    chk("rd_strb_0101", rd, 32'hDE22BE44);
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, rd, err);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err);
    chk("rd_strb_zero", rd, 32'hDE22BE44);

    txn(1, 1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 0, rd, err);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 4, rd, err);
    chk("rd_wait3_hold", rd, 32'hA5A5_5A5A);

    txn(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, rd, err);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h40;
    req_wdata[1] = 32'hCAFEF00D; req_strb[1] = 4'hF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst_ready", 32'(req_ready[1]), 32'd1);
    chk("midrst_rdata", rsp_rdata[1], 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid[1];
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, err);
    chk("midrst_prior", rd, 32'h12345678);

    txn(0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, 0, rd, err);
    txn(0, 1'b1, 32'h1000, 32'h55AA55AA, 4'hF, 0, rd, err);
    chk("oob_err", 32'(err), 32'(CHK));
    chk("oob_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, err);
    chk("oob_word0", rd, CHK ? 32'h0BADC0DE : 32'h55AA55AA);

    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 60; t++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 7) * 4);
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
        txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), rd, err);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_wait_ctrl.md
# dmem_wait_ctrl

Parametrised single-port data memory with byte-lane write strobes, a valid/ready request/response handshake, and a programmable wait-state counter. It is the next-generation data RAM for the core's load/store unit. It replaces the combinational-read array with a registered, latency-configurable access, so slower backing memories can be modelled without changing the LSU protocol.

## Interface
Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of DATA_W words; must be a power of 2.
- ADDR_W, 32, byte-address width.
- BASE_ADDR, 32'h0, byte address of word 0.
- WAIT_CYC, 0, wait states per access; range 0..15.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- req_valid_i, input, 1, request present.
- req_ready_o, output, 1, block can accept a request.
- req_we_i, input, 1, 1 = write, 0 = read.
- req_addr_i, input, ADDR_W, byte address.
- req_wdata_i, input, DATA_W, write data.
- req_strb_i, input, DATA_W/8, byte-lane enables; bit i covers bits [8i+7:8i].
- rsp_valid_o, output, 1, response present.
- rsp_ready_i, input, 1, consumer accepts the response.
- rsp_rdata_o, output, DATA_W, read data; 0 for writes.
- rsp_err_o, output, 1, access error (only with DMEM_RANGE_CHK_EN; otherwise tied 0).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o, latch we/addr/wdata/strb, load wait counter with WAIT_CYC, go to BUSY.
- BUSY: req_ready_o=0. While counter≠0, decrement it. When counter==0, perform the access on that edge and go to RESP.
- Access, read: rsp_rdata_o ← mem[idx], full word; strobes are ignored.
- Access, write: for each lane i with strb[i]=1, mem[idx] lane i ← wdata lane i. Other lanes are unchanged. An all-zero strobe changes nothing but is still acknowledged. rsp_rdata_o ← 0.
- RESP: rsp_valid_o=1. rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o & rsp_ready_i, then the FSM goes to IDLE. rsp_valid_o never drops without a handshake.
- Index: idx = (req_addr − BASE_ADDR) >> log2(DATA_W/8), truncated to log2(DEPTH) bits. Address low bits below the word size are ignored for indexing.
- One outstanding transaction; requests are never pipelined. Minimum period is WAIT_CYC+3 cycles per access.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: FSM=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, counter=0.
- Request accepted at edge E. Access is performed at edge E+WAIT_CYC+1. rsp_valid_o is high from that edge onward.
- With rsp_ready_i held high, rsp_valid_o lasts exactly 1 cycle and req_ready_o returns 1 on the next edge.
- Read-after-write to the same address returns the new data: the write commits at its access edge, before any later request can be accepted.
- Reset asserted in BUSY: the pending write is discarded with no memory change. Reset asserted in RESP: the response is dropped. Outputs go to reset values immediately, asynchronously.
- req_* inputs are sampled only at the accept edge; changes during BUSY or RESP have no effect.

## Configuration
- DMEM_RANGE_CHK_EN defined:
  - The latched request is checked.
  - Error if the word offset ≥ DEPTH, the address is < BASE_ADDR, or the low address bits are nonzero (misaligned).
  - On error: the write is suppressed, rsp_rdata_o=0, rsp_err_o=1. Timing is unchanged.
- DMEM_RANGE_CHK_EN undefined:
  - No checking; rsp_err_o is constant 0.
  - Out-of-range indices wrap modulo DEPTH.
  - Low address bits are ignored.

## Test plan
- Reset, then idle: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0 through 5 cycles with no request.
- WAIT_CYC=0: write addr 0x10, wdata 0xDEADBEEF, strb 4'hF, then read addr 0x10 → rsp_valid_o 1 cycle after each accept; read returns 0xDEADBEEF, rsp_err_o=0.
- Byte strobes: after the word is 0xDEADBEEF, write 0x11223344 with strb 4'b0101 → read returns 0xDE22BE44. A write with strb 0 is acknowledged and the read is unchanged.
- WAIT_CYC=3 with rsp_ready_i held low 4 cycles: rsp_valid_o rises 4 cycles after accept and stays high with stable data until rsp_ready_i=1. req_ready_o stays 0 throughout.
- Reset pulse 2 cycles after accepting a write of 0xCAFEF00D (WAIT_CYC=3): no response is issued, and a subsequent read of that address returns the prior contents.
- DEPTH=1024, addr 0x1000:
  - With DMEM_RANGE_CHK_EN: rsp_err_o=1, rdata 0, and word 0 is unmodified.
  - Without it: the write aliases to word 0, and reading addr 0x0 returns the written data.
